// File: rtl/float_add_arb_pkg.sv
// Shared constants and FSM state type for the arbitrated 8-bit float adder.
// Format: 3-bit exponent, 5-bit significand with explicit leading one.
package float_add_arb_pkg;

    localparam int FLT_W = 8;
    localparam int EXP_W = 3;
    localparam int MAN_W = 5;

    localparam logic [FLT_W-1:0] FLT_MAX = 8'b111_11111;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        RESPOND
    } state_t;

endpackage

// File: rtl/float_add_arb_float_add.sv
// Combinational adder for the 3-bit exponent / 5-bit significand format.
// Aligns to the larger exponent, truncates shifted bits, saturates on exponent overflow.
module float_add
    import float_add_arb_pkg::*;
(
    input  logic [FLT_W-1:0] aIn,
    input  logic [FLT_W-1:0] bIn,
    output logic [FLT_W-1:0] result
);

    logic [EXP_W-1:0] exp_a, exp_b, exp_big, exp_diff;
    logic [MAN_W-1:0] man_a, man_b, man_big, man_small, man_shift, man_norm;
    logic [MAN_W:0]   man_sum;
    logic [EXP_W:0]   exp_sum;

    always_comb begin
        exp_a = aIn[FLT_W-1 -: EXP_W];
        exp_b = bIn[FLT_W-1 -: EXP_W];
        man_a = aIn[MAN_W-1:0];
        man_b = bIn[MAN_W-1:0];

        if (exp_a >= exp_b) begin
            exp_big   = exp_a;
            man_big   = man_a;
            man_small = man_b;
            exp_diff  = exp_a - exp_b;
        end else begin
            exp_big   = exp_b;
            man_big   = man_b;
            man_small = man_a;
            exp_diff  = exp_b - exp_a;
        end

        man_shift = man_small >> exp_diff;
        man_sum   = {1'b0, man_big} + {1'b0, man_shift};

        // A carry out of the significand renormalises by one place.
        man_norm = man_sum[MAN_W] ? man_sum[MAN_W:1] : man_sum[MAN_W-1:0];
        exp_sum  = {1'b0, exp_big} + {{EXP_W{1'b0}}, man_sum[MAN_W]};

        result = exp_sum[EXP_W] ? FLT_MAX : {exp_sum[EXP_W-1:0], man_norm};
    end

endmodule

// File: rtl/float_add_arb.sv
// Round-robin arbiter sharing one float_add between NREQ requesters (IDLE/COMPUTE/RESPOND).
// Optional out_sat output enabled by defining FLOAT_ADD_ARB_SAT_FLAG_EN.
module float_add_arb
    import float_add_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       in_valid,
    output logic [NREQ-1:0]       in_ready,
    input  logic [FLT_W*NREQ-1:0] in_a,
    input  logic [FLT_W*NREQ-1:0] in_b,
    output logic [NREQ-1:0]       out_valid,
    input  logic [NREQ-1:0]       out_ready,
    output logic [FLT_W-1:0]      out_result
`ifdef FLOAT_ADD_ARB_SAT_FLAG_EN
    ,
    output logic                  out_sat
`endif
);

    localparam int IDX_W = $clog2(NREQ);

    state_t           state;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] gnt_idx;
    logic [FLT_W-1:0] op_a, op_b;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand_idx;
    logic [FLT_W-1:0] sel_a, sel_b;
    logic [FLT_W-1:0] sum;

    // Scan from the requester after the last grant so every waiter is reached within NREQ ops.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IDX_W'((int'(last_grant) + k) % NREQ);
            if (state == IDLE && !sel_found && in_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
        in_ready = sel_found ? (NREQ'(1) << sel_idx) : '0;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_a = in_a[FLT_W*i +: FLT_W];
                sel_b = in_b[FLT_W*i +: FLT_W];
            end
        end
    end

    float_add u_float_add (
        .aIn    (op_a),
        .bIn    (op_b),
        .result (sum)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NREQ - 1);
            gnt_idx    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            out_valid  <= '0;
            out_result <= '0;
`ifdef FLOAT_ADD_ARB_SAT_FLAG_EN
            out_sat    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_found) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        gnt_idx    <= sel_idx;
                        last_grant <= sel_idx;
                        state      <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    out_result <= sum;
`ifdef FLOAT_ADD_ARB_SAT_FLAG_EN
                    out_sat    <= (sum == FLT_MAX);
`endif
                    out_valid  <= NREQ'(1) << gnt_idx;
                    state      <= RESPOND;
                end
                RESPOND: begin
                    if (out_ready[gnt_idx]) begin
                        out_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_add_arb.sv
// Scoreboard bench for float_add_arb (NREQ=2): directed vectors, monitor pops on result handshake.
// Also covers the FLOAT_ADD_ARB_SAT_FLAG_EN build when that macro is defined.
module tb_float_add_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [15:0] in_a, in_b;
    logic [1:0]  out_valid;
    logic [1:0]  out_ready;
    logic [7:0]  out_result;
`ifdef FLOAT_ADD_ARB_SAT_FLAG_EN
    logic        out_sat;
`endif

    float_add_arb #(.NREQ(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
`ifdef FLOAT_ADD_ARB_SAT_FLAG_EN
        ,
        .out_sat    (out_sat)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] res;
        logic       sat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input logic [7:0] res, input logic sat);
        exp_t e;
        e.idx = idx;
        e.res = res;
        e.sat = sat;
        sb.push_back(e);
    endtask

    // Monitor: every result handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && (out_valid & out_ready) != 2'b00) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got out_valid %b result %h, expected none",
                         out_valid, out_result);
            end else begin
                exp_t       e;
                logic [1:0] oh;
                e      = sb.pop_front();
                oh     = 2'b00;
                oh[e.idx] = 1'b1;
                check("out_idx", 32'(out_valid), 32'(oh));
                check("out_result", 32'(out_result), 32'(e.res));
`ifdef FLOAT_ADD_ARB_SAT_FLAG_EN
                check("out_sat", 32'(out_sat), 32'(e.sat));
`endif
            end
        end
    end

    task automatic wait_grant(output logic [1:0] g, output int cyc);
        g   = 2'b00;
        cyc = 0;
        while (g == 2'b00 && cyc < 20) begin
            @(negedge clk);
            g = in_valid & in_ready;
            if (g == 2'b00) cyc++;
        end
        if (g == 2'b00) begin
            tests++;
            fails++;
            $display("FAIL grant_timeout: got no grant, expected one within 20 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [1:0] g;
    int         cyc;

    initial begin
        reset     = 1'b1;
        in_valid  = 2'b00;
        in_a      = 16'h0;
        in_b      = 16'h0;
        out_ready = 2'b11;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
`ifdef FLOAT_ADD_ARB_SAT_FLAG_EN
        check("rst_out_sat", 32'(out_sat), 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single request, latency 2: 000_10000 + 000_10000 = 001_10000
        push(0, 8'h30, 1'b0);
        in_valid = 2'b01;
        in_a     = 16'h0010;
        in_b     = 16'h0010;
        wait_grant(g, cyc);
        check("t1_grant", 32'(g), 32'd1);
        check("t1_first_edge", 32'(cyc), 32'd0);
        in_valid = 2'b00;
        @(negedge clk);
        check("t1_compute_valid", 32'(out_valid), 32'd0);
        check("t1_compute_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t1_latency", 32'(out_valid), 32'd1);
        drain();

        // Simultaneous after reset; req0 re-requests while req1 waits -> 0, 1, 0
        do_reset();
        push(0, 8'h92, 1'b0);
        push(1, 8'h9E, 1'b0);
        push(0, 8'h70, 1'b0);
        in_valid = 2'b11;
        in_a     = {8'h94, 8'h90};
        in_b     = {8'h74, 8'h30};
        wait_grant(g, cyc);
        check("t2_grant_a", 32'(g), 32'd1);
        in_a[7:0] = 8'h50;
        in_b[7:0] = 8'h50;
        wait_grant(g, cyc);
        check("t2_grant_b", 32'(g), 32'd2);
        in_valid = 2'b01;
        wait_grant(g, cyc);
        check("t2_grant_c", 32'(g), 32'd1);
        in_valid = 2'b00;
        drain();

        // Next simultaneous pair starts after last grant 0 -> req1 first
        push(1, 8'h70, 1'b0);
        push(0, 8'h50, 1'b0);
        in_valid = 2'b11;
        in_a     = {8'h50, 8'h38};
        in_b     = {8'h50, 8'h10};
        wait_grant(g, cyc);
        check("t3_grant_a", 32'(g), 32'd2);
        in_valid = 2'b01;
        wait_grant(g, cyc);
        check("t3_grant_b", 32'(g), 32'd1);
        in_valid = 2'b00;
        drain();

        // Saturation: 111_10000 + 111_10000
        push(0, 8'hFF, 1'b1);
        in_valid = 2'b01;
        in_a     = {8'h00, 8'hF0};
        in_b     = {8'h00, 8'hF0};
        wait_grant(g, cyc);
        check("t4_grant", 32'(g), 32'd1);
        in_valid = 2'b00;
        drain();

        // Backpressure on req0; req1 pending with its out_ready high must not matter
        push(0, 8'h58, 1'b0);
        push(1, 8'h30, 1'b0);
        out_ready = 2'b10;
        in_valid  = 2'b01;
        in_a      = {8'h10, 8'h50};
        in_b      = {8'h10, 8'h30};
        wait_grant(g, cyc);
        check("t5_grant", 32'(g), 32'd1);
        in_valid = 2'b10;
        @(negedge clk);
        check("t5_compute_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_result", 32'(out_result), 32'h58);
            check("t5_hold_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 2'b11;
        @(negedge clk);
        check("t5_respond_ready", 32'(in_ready), 32'd0);
        wait_grant(g, cyc);
        check("t5_idle_grant", 32'(g), 32'd2);
        check("t5_idle_delay", 32'(cyc), 32'd0);
        in_valid = 2'b00;
        drain();

        // Reset in COMPUTE aborts: no result, next grant to req0 on first edge
        in_valid = 2'b10;
        in_a     = {8'h10, 8'h00};
        in_b     = {8'h10, 8'h00};
        wait_grant(g, cyc);
        check("t6_grant", 32'(g), 32'd2);
        in_valid = 2'b00;
        reset    = 1'b1;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_ready", 32'(in_ready), 32'd0);
        check("t6_rst_result", 32'(out_result), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        push(0, 8'h50, 1'b0);
        push(1, 8'h30, 1'b0);
        in_valid = 2'b11;
        in_a     = {8'h10, 8'h30};
        in_b     = {8'h10, 8'h30};
        wait_grant(g, cyc);
        check("t6_grant_after", 32'(g), 32'd1);
        check("t6_first_edge", 32'(cyc), 32'd0);
        in_valid = 2'b10;
        wait_grant(g, cyc);
        check("t6_grant_next", 32'(g), 32'd2);
        in_valid = 2'b00;
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/float_add_arb.md
FLOAT_ADD_ARB -- requirements
Module: float_add_arb

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters sharing the adder; legal values 2..4.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: in_valid  input  NREQ  per-requester operand-valid.
REQ-006 Port: in_ready  output  NREQ  per-requester operand-accept; one-hot or zero.
REQ-007 Port: in_a  input  8*NREQ  operand A of requester i in bits [8i+7:8i]; format 3-bit exponent, 5-bit significand.
REQ-008 Port: in_b  input  8*NREQ  operand B of requester i, same packing.
REQ-009 Port: out_valid  output  NREQ  per-requester result-valid; one-hot or zero.
REQ-010 Port: out_ready  input  NREQ  per-requester result-accept.
REQ-011 Port: out_result  output  8  registered sum; meaningful only while some out_valid bit is high.

Function
REQ-012 Three states: IDLE, COMPUTE, RESPOND.
REQ-013 IDLE: grant the first requester with in_valid high, scanning round-robin from (last_grant+1) mod NREQ; in_ready = grant one-hot, combinational from in_valid and the pointer.
REQ-014 IDLE with no in_valid: in_ready all zero; stay in IDLE.
REQ-015 Handshake (in_valid[i] & in_ready[i]) in cycle T: latch in_a[i], in_b[i] and index i; last_grant <= i; go to COMPUTE.
REQ-016 COMPUTE (T+1): drive latched operands into the shared float_add; register its result into out_result; go to RESPOND.
REQ-017 RESPOND: out_valid[i] high from T+2; hold it and out_result stable until out_ready[i] is high; then go to IDLE in the next cycle.
REQ-018 Throughput: at most one operation per 3 cycles; minimum latency from accept to out_valid is 2 cycles.
REQ-019 in_ready is zero in COMPUTE and RESPOND; in_valid is ignored there. Requesters hold in_valid and operands until accepted.
REQ-020 out_ready bits of non-granted requesters are ignored.
REQ-021 Simultaneous requests: exactly one grant; a requester waiting with in_valid high is served within NREQ operations.
REQ-022 Arithmetic, including saturation to 8'b111_11111, is float_add's; this block never modifies the sum.

Reset
REQ-023 On reset assertion, asynchronously: state=IDLE, last_grant=NREQ-1 (so requester 0 has first priority), in_ready=0, out_valid=0, out_result=8'h00, latched operands=0.
REQ-024 Reset during COMPUTE or RESPOND aborts the operation; no out_valid is produced for it.
REQ-025 First grant is possible in the first clock edge after reset deasserts.

Configuration
REQ-026 Macro FLOAT_ADD_ARB_SAT_FLAG_EN defined: extra output out_sat (1 bit), registered with out_result; high when the registered sum equals 8'b111_11111; reset value 0.
REQ-027 Macro undefined: no out_sat port; all other behaviour identical.

Structure
REQ-028 Package float_add_arb_pkg holds FLT_W=8, EXP_W=3, MAN_W=5, FLT_MAX=8'b111_11111, and the state typedef (IDLE, COMPUTE, RESPOND).
REQ-029 Exactly one sub-module: a single instance of the existing combinational float_add (ports aIn, bIn, result).

Verification
REQ-030 Single request: requester 0 sends 000_10000 + 000_10000 -> out_valid[0] 2 cycles after accept, out_result=001_10000.
REQ-031 Simultaneous requests after reset: req0 100_10000+001_10000, req1 100_10100+011_10100 -> req0 served first (100_10010), then req1 (100_11110); next simultaneous pair is served req1 first.
REQ-032 Saturation: 111_10000 + 111_10000 -> out_result=111_11111; out_sat=1 with the macro defined.
REQ-033 Backpressure: out_ready[0] held low 5 cycles -> out_valid[0] and out_result stay stable, in_ready stays 0, then IDLE one cycle after out_ready rises.
REQ-034 Reset asserted in COMPUTE -> outputs go to reset values immediately; no out_valid; next grant goes to requester 0.
